// File: rtl/peripheral_bus_pkg.sv
// -----------------------------------------------------------------------------
// peripheral_bus_pkg
// Shared definitions for the peripheral bus arbiter: FSM state encoding, bus
// field widths, the value returned on unclaimed or aborted reads, and the
// helper that sizes the optional access timeout counter.
// -----------------------------------------------------------------------------
package peripheral_bus_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } arb_state_e;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 32;
   localparam int BSEL_W = 4;

   localparam logic [DATA_W-1:0] READ_DEFAULT = 32'hFFFF_FFFF;

   // Timeout counter width: wide enough for TIMEOUT-1, kept within 8..16 bits.
   function automatic int cnt_width(input int timeout);
      int w;
      w = $clog2(timeout);
      if (w < 8)  w = 8;
      if (w > 16) w = 16;
      return w;
   endfunction

endpackage

// File: rtl/peripheral_bus_arbiter_round_robin_select.sv
// -----------------------------------------------------------------------------
// round_robin_select
// Combinational round-robin pick: returns the first asserted request found
// searching upward from last+1 and wrapping around to last.
//
// Ports
//   req   : request vector, one bit per master
//   last  : index of the most recently served master
//   idx   : winning master index (0 when nothing is requested)
//   valid : at least one request present
// -----------------------------------------------------------------------------
module round_robin_select #(
   parameter int MASTERS = 2,
   parameter int IDX_W   = $clog2(MASTERS)
) (
   input  logic [MASTERS-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [IDX_W-1:0]   idx,
   output logic               valid
);

   // Two passes over a fixed index range: masters above 'last' have priority,
   // then the wrapped-around ones up to and including 'last'.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int j = 0; j < MASTERS; j++) begin
         if (!valid && req[j] && (j > int'(last))) begin
            valid = 1'b1;
            idx   = IDX_W'(j);
         end
      end
      for (int j = 0; j < MASTERS; j++) begin
         if (!valid && req[j] && (j <= int'(last))) begin
            valid = 1'b1;
            idx   = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/peripheral_bus_arbiter.sv
// -----------------------------------------------------------------------------
// peripheral_bus_arbiter
// Round-robin arbiter sharing one peripheral bus between MASTERS requesters.
// One master is granted at a time and its transaction is forwarded unchanged;
// the grant is released when the slave drops busy, when the granted master
// withdraws its strobes, or (optionally) when the access times out.
//
// Build option
//   PERIPHERAL_ARBITER_TIMEOUT_EN : when defined, an access still busy after
//   TIMEOUT cycles is force-completed with read data 32'hFFFF_FFFF and a
//   one-cycle timeout_error pulse. When undefined, ACCESS waits indefinitely
//   and timeout_error is tied low.
//
// Ports
//   clk, rst                 : clock, asynchronous active-low reset
//   master_we/oe             : per-master write/read strobes
//   master_address/byteSelect/dataWrite : flattened per-master bus fields
//   master_busy              : per-master busy, low ends that master's access
//   master_dataRead          : read data broadcast to all masters
//   master_requestOutput     : slave requestOutput routed to granted master
//   timeout_error            : pulse on a timed-out access
//   peripheralBus_*          : shared bus toward the slaves
//   requestOutput            : slave claims the current read
// -----------------------------------------------------------------------------
module peripheral_bus_arbiter
   import peripheral_bus_pkg::*;
#(
   parameter int MASTERS = 2,
   parameter int TIMEOUT = 256
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [MASTERS-1:0]          master_we,
   input  logic [MASTERS-1:0]          master_oe,
   input  logic [ADDR_W*MASTERS-1:0]   master_address,
   input  logic [BSEL_W*MASTERS-1:0]   master_byteSelect,
   input  logic [DATA_W*MASTERS-1:0]   master_dataWrite,
   output logic [MASTERS-1:0]          master_busy,
   output logic [DATA_W-1:0]           master_dataRead,
   output logic [MASTERS-1:0]          master_requestOutput,
   output logic                        timeout_error,
   output logic                        peripheralBus_we,
   output logic                        peripheralBus_oe,
   output logic [ADDR_W-1:0]           peripheralBus_address,
   output logic [BSEL_W-1:0]           peripheralBus_byteSelect,
   output logic [DATA_W-1:0]           peripheralBus_dataWrite,
   input  logic                        peripheralBus_busy,
   input  logic [DATA_W-1:0]           peripheralBus_dataRead,
   input  logic                        requestOutput
);

   localparam int IDX_W = $clog2(MASTERS);

   generate
      if (MASTERS < 2 || MASTERS > 8) begin : g_bad_masters
         $error("peripheral_bus_arbiter: MASTERS must be 2..8");
      end
      if (TIMEOUT < 2) begin : g_bad_timeout
         $error("peripheral_bus_arbiter: TIMEOUT must be at least 2");
      end
   endgenerate

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] last_q,  last_d;

   logic [MASTERS-1:0] req;
   logic [MASTERS-1:0] gnt_oh;
   logic [IDX_W-1:0]   sel_idx;
   logic               sel_valid;

   logic               in_access;
   logic               g_we, g_oe, g_req;
   logic [ADDR_W-1:0]  g_addr;
   logic [BSEL_W-1:0]  g_bsel;
   logic [DATA_W-1:0]  g_data;
   logic               tmo_fire;
   logic               done;
   logic               end_access;

   generate
      for (genvar i = 0; i < MASTERS; i++) begin : g_master
         assign req[i]    = master_we[i] | master_oe[i];
         assign gnt_oh[i] = (grant_q == IDX_W'(i));
      end
   endgenerate

   round_robin_select #(
      .MASTERS (MASTERS),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req   (req),
      .last  (last_q),
      .idx   (sel_idx),
      .valid (sel_valid)
   );

   // Fields of the granted master, selected by the one-hot decode of grant_q.
   always_comb begin
      g_we   = 1'b0;
      g_oe   = 1'b0;
      g_addr = '0;
      g_bsel = '0;
      g_data = '0;
      for (int i = 0; i < MASTERS; i++) begin
         if (gnt_oh[i]) begin
            g_we   = master_we[i];
            g_oe   = master_oe[i];
            g_addr = master_address[i*ADDR_W +: ADDR_W];
            g_bsel = master_byteSelect[i*BSEL_W +: BSEL_W];
            g_data = master_dataWrite[i*DATA_W +: DATA_W];
         end
      end
   end

   assign in_access = (state_q == ACCESS);
   assign g_req     = g_we | g_oe;

`ifdef PERIPHERAL_ARBITER_TIMEOUT_EN
   localparam int CNT_W = cnt_width(TIMEOUT);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Held at zero outside ACCESS, so it starts from zero on every grant.
   always_comb begin
      cnt_d = cnt_q;
      if (!in_access)
         cnt_d = '0;
      else if (peripheralBus_busy)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign tmo_fire = in_access & g_req & peripheralBus_busy &
                     (cnt_q == CNT_W'(TIMEOUT - 1));
`else
   assign tmo_fire = 1'b0;
`endif

   // done: the granted access completes this cycle (slave ready or timeout).
   // end_access additionally covers the granted master withdrawing.
   assign done       = in_access & g_req & (~peripheralBus_busy | tmo_fire);
   assign end_access = in_access & (~g_req | done);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(MASTERS - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (sel_valid) begin
               grant_d = sel_idx;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (end_access) begin
               last_d  = grant_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Strobes are state-qualified, so an asynchronous reset drops them at once.
   // A simultaneous we/oe is treated as a write.
   assign peripheralBus_we         = in_access & g_we;
   assign peripheralBus_oe         = in_access & g_oe & ~g_we;
   assign peripheralBus_address    = g_addr;
   assign peripheralBus_byteSelect = g_bsel;
   assign peripheralBus_dataWrite  = g_data;

   assign master_busy          = req & ~(gnt_oh & {MASTERS{done}});
   assign master_requestOutput = gnt_oh & {MASTERS{in_access & requestOutput}};
   assign master_dataRead      = (requestOutput & ~tmo_fire) ? peripheralBus_dataRead
                                                             : READ_DEFAULT;
   assign timeout_error        = tmo_fire;

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
module tb_peripheral_bus_arbiter;

   localparam int M   = 2;
   localparam int TMO = 4;
`ifdef PERIPHERAL_ARBITER_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [M-1:0]     master_we, master_oe;
   logic [24*M-1:0]  master_address;
   logic [4*M-1:0]   master_byteSelect;
   logic [32*M-1:0]  master_dataWrite;
   logic [M-1:0]     master_busy;
   logic [31:0]      master_dataRead;
   logic [M-1:0]     master_requestOutput;
   logic             timeout_error;
   logic             peripheralBus_we, peripheralBus_oe;
   logic [23:0]      peripheralBus_address;
   logic [3:0]       peripheralBus_byteSelect;
   logic [31:0]      peripheralBus_dataWrite;
   logic             peripheralBus_busy;
   logic [31:0]      peripheralBus_dataRead;
   logic             requestOutput;

   logic [23:0] m_addr [M];
   logic [3:0]  m_bs   [M];
   logic [31:0] m_dw   [M];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   always_comb begin
      master_address    = '0;
      master_byteSelect = '0;
      master_dataWrite  = '0;
      for (int i = 0; i < M; i++) begin
         master_address[i*24 +: 24]  = m_addr[i];
         master_byteSelect[i*4 +: 4] = m_bs[i];
         master_dataWrite[i*32 +: 32] = m_dw[i];
      end
   end

   peripheral_bus_arbiter #(.MASTERS(M), .TIMEOUT(TMO)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .master_we                (master_we),
      .master_oe                (master_oe),
      .master_address           (master_address),
      .master_byteSelect        (master_byteSelect),
      .master_dataWrite         (master_dataWrite),
      .master_busy              (master_busy),
      .master_dataRead          (master_dataRead),
      .master_requestOutput     (master_requestOutput),
      .timeout_error            (timeout_error),
      .peripheralBus_we         (peripheralBus_we),
      .peripheralBus_oe         (peripheralBus_oe),
      .peripheralBus_address    (peripheralBus_address),
      .peripheralBus_byteSelect (peripheralBus_byteSelect),
      .peripheralBus_dataWrite  (peripheralBus_dataWrite),
      .peripheralBus_busy       (peripheralBus_busy),
      .peripheralBus_dataRead   (peripheralBus_dataRead),
      .requestOutput            (requestOutput)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // One clock: inputs are changed just after the rising edge by the caller,
   // outputs are sampled on the falling edge.
   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic to_sample();
      @(negedge clk);
   endtask

   typedef struct {
      logic        rst;
      logic [1:0]  we, oe;
      logic        pbusy, ro;
      logic        exp_we, exp_oe;
      logic [1:0]  exp_busy;
      int          exp_g;      // granted master whose fields are on the bus, -1 none
      logic [31:0] exp_dr;
   } vec_t;

   localparam int NV = 15;
   vec_t tbl [NV];

   // Reference model state for the random phase.
   int owner, last, tc;

   task automatic new_req(input int i);
      logic [1:0] wo;
      wo = 2'($urandom_range(1, 3));
      master_we[i] = wo[1];
      master_oe[i] = wo[0];
      m_addr[i] = 24'($urandom);
      m_bs[i]   = 4'($urandom);
      m_dw[i]   = $urandom;
   endtask

   task automatic drop_req(input int i);
      master_we[i] = 1'b0;
      master_oe[i] = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [M-1:0] prev_busy;
      logic [1:0]   exp_ro;
      int           nacc, g, persist;

      tbl = '{
         '{1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, -1, 32'hFFFF_FFFF},
         '{1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01,  0, 32'hFFFF_FFFF},
         '{1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01,  0, 32'hFFFF_FFFF},
         '{1'b1, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00,  0, 32'h0000_00A5},
         '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1, 32'hFFFF_FFFF},
         '{1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, -1, 32'hFFFF_FFFF},
         '{1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10,  0, 32'hFFFF_FFFF},
         '{1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, -1, 32'hFFFF_FFFF},
         '{1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,  1, 32'hFFFF_FFFF},
         '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1, 32'hFFFF_FFFF},
         '{1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, -1, 32'hFFFF_FFFF},
         '{1'b1, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00,  0, 32'h0000_00A5},
         '{1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, -1, 32'hFFFF_FFFF},
         '{1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00,  1, 32'hFFFF_FFFF},
         '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, -1, 32'hFFFF_FFFF}
      };

      rst = 1'b0;
      master_we = '0; master_oe = '0;
      m_addr[0] = 24'h010004; m_bs[0] = 4'hF; m_dw[0] = 32'h1111_1111;
      m_addr[1] = 24'h020008; m_bs[1] = 4'h3; m_dw[1] = 32'h2222_2222;
      peripheralBus_busy = 1'b0;
      peripheralBus_dataRead = 32'h0000_00A5;
      requestOutput = 1'b0;

      to_sample();
      chk("reset_we", peripheralBus_we, 1'b0);
      chk("reset_oe", peripheralBus_oe, 1'b0);
      chk("reset_busy", master_busy, 2'b00);
      chk("reset_terr", timeout_error, 1'b0);
      to_drive();

      // ---------------- table: single read, contention, we+oe, unclaimed read
      for (int r = 0; r < NV; r++) begin
         to_drive();
         rst                = tbl[r].rst;
         master_we          = tbl[r].we;
         master_oe          = tbl[r].oe;
         peripheralBus_busy = tbl[r].pbusy;
         requestOutput      = tbl[r].ro;
         to_sample();
         chk($sformatf("tbl%0d_pb_we", r), peripheralBus_we, tbl[r].exp_we);
         chk($sformatf("tbl%0d_pb_oe", r), peripheralBus_oe, tbl[r].exp_oe);
         chk($sformatf("tbl%0d_busy", r), master_busy, tbl[r].exp_busy);
         chk($sformatf("tbl%0d_rdata", r), master_dataRead, tbl[r].exp_dr);
         chk($sformatf("tbl%0d_terr", r), timeout_error, 1'b0);
         exp_ro = '0;
         if (tbl[r].exp_g >= 0) begin
            g = tbl[r].exp_g;
            if (tbl[r].ro) exp_ro[g] = 1'b1;
            chk($sformatf("tbl%0d_addr", r), peripheralBus_address, m_addr[g]);
            chk($sformatf("tbl%0d_bsel", r), peripheralBus_byteSelect, m_bs[g]);
            chk($sformatf("tbl%0d_wdata", r), peripheralBus_dataWrite, m_dw[g]);
         end
         chk($sformatf("tbl%0d_reqout", r), master_requestOutput, exp_ro);
      end

      // ---------------- fairness: both masters write continuously after reset
      to_drive();
      rst = 1'b0;
      to_drive();
      rst = 1'b1;
      master_we = 2'b11; master_oe = 2'b00;
      peripheralBus_busy = 1'b0;
      nacc = 0;
      for (int c = 0; c < 16; c++) begin
         to_sample();
         if (peripheralBus_we) begin
            g = master_busy[0] ? 1 : 0;
            chk($sformatf("fair_grant%0d", nacc), g, nacc % 2);
            chk($sformatf("fair_addr%0d", nacc), peripheralBus_address, m_addr[nacc % 2]);
            nacc++;
         end
         to_drive();
      end
      chk("fair_count", nacc, 8);
      master_we = 2'b00;

      // ---------------- withdrawal: grant released, last pointer moves
      to_drive();
      master_oe = 2'b01; peripheralBus_busy = 1'b1;   // idle, m0 requests
      to_drive();
      to_sample();
      chk("wd_access_oe", peripheralBus_oe, 1'b1);
      to_drive();
      master_oe = 2'b00;                               // m0 withdraws mid-busy
      to_sample();
      chk("wd_drop_oe", peripheralBus_oe, 1'b0);
      chk("wd_drop_busy", master_busy, 2'b00);
      chk("wd_drop_terr", timeout_error, 1'b0);
      to_drive();
      master_oe = 2'b11; peripheralBus_busy = 1'b0;    // back in IDLE, both ask
      to_sample();
      chk("wd_idle_oe", peripheralBus_oe, 1'b0);
      chk("wd_idle_busy", master_busy, 2'b11);
      to_drive();
      to_sample();
      chk("wd_next_addr", peripheralBus_address, m_addr[1]);
      chk("wd_next_busy", master_busy, 2'b01);
      to_drive();
      master_oe = 2'b01;
      to_drive();
      to_sample();
      chk("wd_m0_busy", master_busy, 2'b00);
      to_drive();
      master_oe = 2'b00;

      // ---------------- reset in the middle of an access
      to_drive();
      master_oe = 2'b01; peripheralBus_busy = 1'b1;
      to_drive();
      to_sample();
      chk("rst_pre_oe", peripheralBus_oe, 1'b1);
      #2 rst = 1'b0;
      #1;
      chk("rst_async_oe", peripheralBus_oe, 1'b0);
      chk("rst_async_we", peripheralBus_we, 1'b0);
      chk("rst_no_complete", master_busy, 2'b01);
      to_drive();
      rst = 1'b1; master_oe = 2'b11; peripheralBus_busy = 1'b0;
      to_sample();
      chk("rst_idle_busy", master_busy, 2'b11);
      to_drive();
      to_sample();
      chk("rst_m0_wins_addr", peripheralBus_address, m_addr[0]);
      chk("rst_m0_wins_busy", master_busy, 2'b10);
      to_drive();
      master_oe = 2'b00;

      // ---------------- slave busy forever
      to_drive();
      master_oe = 2'b01; peripheralBus_busy = 1'b1;
      requestOutput = 1'b1; peripheralBus_dataRead = 32'h0000_00A5;
      if (TMO_EN) begin
         for (int k = 1; k <= TMO; k++) begin
            to_drive();
            to_sample();
            chk($sformatf("tmo_oe%0d", k), peripheralBus_oe, 1'b1);
            chk($sformatf("tmo_busy%0d", k), master_busy[0], (k < TMO) ? 1'b1 : 1'b0);
            chk($sformatf("tmo_terr%0d", k), timeout_error, (k == TMO) ? 1'b1 : 1'b0);
            if (k == TMO) chk("tmo_rdata", master_dataRead, 32'hFFFF_FFFF);
         end
         to_drive();
         master_oe = 2'b00;
         to_sample();
         chk("tmo_terr_after", timeout_error, 1'b0);
         chk("tmo_idle_oe", peripheralBus_oe, 1'b0);
      end else begin
         persist = 0;
         for (int k = 1; k <= 110; k++) begin
            to_drive();
            to_sample();
            if (master_busy[0] && peripheralBus_oe && !timeout_error) persist++;
         end
         chk("notmo_persist", persist, 110);
         to_drive();
         master_oe = 2'b00;
         to_sample();
         chk("notmo_release_oe", peripheralBus_oe, 1'b0);
      end
      requestOutput = 1'b0;

      // ---------------- randomized traffic against the reference model
      to_drive();
      rst = 1'b0;
      master_we = '0; master_oe = '0;
      to_drive();
      rst = 1'b1;
      owner = -1; last = M - 1; tc = 0;
      prev_busy = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic [M-1:0] req, exp_busy, exp_rout;
         logic         exp_we, exp_oe, hit, complete, rq;
         logic [31:0]  exp_dr;
         bit           found;
         int           c;
         to_drive();
         for (int i = 0; i < M; i++) begin
            if (master_we[i] | master_oe[i]) begin
               if (!prev_busy[i]) begin
                  if ($urandom_range(0, 1) == 1) new_req(i); else drop_req(i);
               end else if ($urandom_range(0, 15) == 0) begin
                  drop_req(i);
               end
            end else if ($urandom_range(0, 1) == 1) begin
               new_req(i);
            end
         end
         peripheralBus_busy     = ($urandom_range(0, 2) != 0);
         requestOutput          = 1'($urandom_range(0, 1));
         peripheralBus_dataRead = $urandom;
         to_sample();

         req      = master_we | master_oe;
         exp_busy = req;
         exp_rout = '0;
         exp_we   = 1'b0;
         exp_oe   = 1'b0;
         hit      = 1'b0;
         complete = 1'b0;
         rq       = 1'b0;
         exp_dr   = requestOutput ? peripheralBus_dataRead : 32'hFFFF_FFFF;
         if (owner >= 0) begin
            rq       = master_we[owner] | master_oe[owner];
            hit      = TMO_EN && rq && peripheralBus_busy && (tc == TMO - 1);
            complete = rq && (!peripheralBus_busy || hit);
            exp_we   = master_we[owner];
            exp_oe   = master_oe[owner] && !master_we[owner];
            if (complete) exp_busy[owner] = 1'b0;
            exp_rout[owner] = requestOutput;
            if (hit) exp_dr = 32'hFFFF_FFFF;
         end
         chk($sformatf("rnd%0d_pb_we", cyc), peripheralBus_we, exp_we);
         chk($sformatf("rnd%0d_pb_oe", cyc), peripheralBus_oe, exp_oe);
         chk($sformatf("rnd%0d_busy", cyc), master_busy, exp_busy);
         chk($sformatf("rnd%0d_rdata", cyc), master_dataRead, exp_dr);
         chk($sformatf("rnd%0d_reqout", cyc), master_requestOutput, exp_rout);
         chk($sformatf("rnd%0d_terr", cyc), timeout_error, hit);
         if (owner >= 0 && rq) begin
            chk($sformatf("rnd%0d_addr", cyc), peripheralBus_address, m_addr[owner]);
            chk($sformatf("rnd%0d_wdata", cyc), peripheralBus_dataWrite, m_dw[owner]);
            chk($sformatf("rnd%0d_bsel", cyc), peripheralBus_byteSelect, m_bs[owner]);
         end
         prev_busy = master_busy;

         // model advance at the coming clock edge
         if (owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= M; k++) begin
               c = (last + k) % M;
               if (!found && req[c]) begin
                  found = 1'b1;
                  owner = c;
                  tc    = 0;
               end
            end
         end else if (!rq || complete) begin
            last  = owner;
            owner = -1;
         end else if (peripheralBus_busy) begin
            tc++;
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
